// File: rtl/i2c_master_if.sv
// Host-side request/response bundle of the I2C master: the host drives newd/op/addr/din,
// the core returns dout/busy/ack_err/done.
interface i2c_master_if;
    logic       newd;
    logic       op;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       ack_err;
    logic       done;

    modport master (output newd, op, addr, din, input  dout, busy, ack_err, done);
    modport slave  (input  newd, op, addr, din, output dout, busy, ack_err, done);
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C master, quarter-bit timed; done pulses 20 bit periods after newd is taken (11 on abort).
// newd is ignored while busy and never queued; I2C_MASTER_NACK_ABORT_EN makes an address NACK jump to STOP.
module i2c_master #(
    parameter int sys_freq = 40000000,
    parameter int i2c_freq = 100000
) (
    input  logic        clk,
    input  logic        rst,
    i2c_master_if.slave bus,
    output logic        scl,
    inout  wire         sda
);
    localparam int            Q    = sys_freq / i2c_freq / 4;
    localparam int            CW   = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CW-1:0] QMAX = CW'(Q - 1);

    typedef enum logic [3:0] {IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, MACK, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    sh, sh_n, rx, rx_n, din_q, din_n, dout_q, dout_n;
    logic          op_q, op_n, scl_n;
    logic          sda_o, sda_o_n, sda_en, sda_en_n;
    logic          busy_q, busy_n, ack_err_q, ack_err_n, done_q, done_n;
    logic          tick, bit_end, sample, upd;

    assign tick    = (cnt == QMAX);
    assign bit_end = tick && (phase == 2'd3);
    assign sample  = (phase == 2'd2) && (cnt == '0);

    assign sda         = sda_en ? sda_o : 1'bz;
    assign bus.dout    = dout_q;
    assign bus.busy    = busy_q;
    assign bus.ack_err = ack_err_q;
    assign bus.done    = done_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        phase_n   = phase;
        bitn_n    = bitn;
        sh_n      = sh;
        rx_n      = rx;
        din_n     = din_q;
        dout_n    = dout_q;
        op_n      = op_q;
        busy_n    = busy_q;
        ack_err_n = ack_err_q;
        done_n    = 1'b0;
        sda_o_n   = sda_o;
        sda_en_n  = sda_en;
        scl_n     = 1'b1;
        upd       = 1'b0;

        if (state == IDLE) begin
            cnt_n   = '0;
            phase_n = 2'd0;
            bitn_n  = 3'd0;
            if (bus.newd) begin
                state_n   = START;
                op_n      = bus.op;
                din_n     = bus.din;
                sh_n      = {bus.addr, bus.op};
                busy_n    = 1'b1;
                ack_err_n = 1'b0;
                upd       = 1'b1;
            end
        end else begin
            cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
                phase_n = phase + 2'd1;
                upd     = 1'b1;
            end
            if (sample) begin
                case (state)
                    ACK1, ACK2: ack_err_n = ack_err_q | sda;
                    RDATA: begin
                        rx_n = {rx[6:0], sda};
                        if (bitn == 3'd7) dout_n = {rx[6:0], sda};
                    end
                    default: ;
                endcase
            end
            if (bit_end) begin
                case (state)
                    START: state_n = ADDR;
                    ADDR: begin
                        sh_n   = {sh[6:0], 1'b0};
                        bitn_n = bitn + 3'd1;
                        if (bitn == 3'd7) state_n = ACK1;
                    end
                    ACK1: begin
                        sh_n = din_q;
`ifdef I2C_MASTER_NACK_ABORT_EN
                        if (ack_err_q) state_n = STOP;
                        else           state_n = op_q ? RDATA : WDATA;
`else
                        state_n = op_q ? RDATA : WDATA;
`endif
                    end
                    WDATA: begin
                        sh_n   = {sh[6:0], 1'b0};
                        bitn_n = bitn + 3'd1;
                        if (bitn == 3'd7) state_n = ACK2;
                    end
                    RDATA: begin
                        bitn_n = bitn + 3'd1;
                        if (bitn == 3'd7) state_n = MACK;
                    end
                    ACK2, MACK: state_n = STOP;
                    STOP: begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        // Outputs are registered, so they are decoded from the state/phase of the coming cycle.
        case (state_n)
            IDLE, START: scl_n = 1'b1;
            STOP:        scl_n = (phase_n != 2'd0);
            default:     scl_n = phase_n[1];
        endcase

        if (upd) begin
            case (state_n)
                IDLE: sda_en_n = 1'b0;
                START: begin
                    sda_en_n = 1'b1;
                    sda_o_n  = ~phase_n[1];
                end
                ADDR, WDATA: if (phase_n == 2'd1) begin
                    sda_en_n = 1'b1;
                    sda_o_n  = sh[7];
                end
                ACK1, ACK2, RDATA: if (phase_n == 2'd1) sda_en_n = 1'b0;
                MACK: if (phase_n == 2'd1) begin
                    sda_en_n = 1'b1;
                    sda_o_n  = 1'b1;
                end
                STOP: if (phase_n == 2'd0 || phase_n == 2'd2) begin
                    sda_en_n = 1'b1;
                    sda_o_n  = phase_n[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= 2'd0;
            bitn      <= 3'd0;
            sh        <= 8'h00;
            rx        <= 8'h00;
            din_q     <= 8'h00;
            dout_q    <= 8'h00;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl       <= 1'b1;
            sda_o     <= 1'b1;
            sda_en    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            phase     <= phase_n;
            bitn      <= bitn_n;
            sh        <= sh_n;
            rx        <= rx_n;
            din_q     <= din_n;
            dout_q    <= dout_n;
            op_q      <= op_n;
            busy_q    <= busy_n;
            ack_err_q <= ack_err_n;
            done_q    <= done_n;
            scl       <= scl_n;
            sda_o     <= sda_o_n;
            sda_en    <= sda_en_n;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: bus monitor plus responding slave, transaction-level reference model.
module tb_i2c_master;
    localparam int SYS = 40000000;
    localparam int I2C = 100000;
    localparam int Q   = SYS / I2C / 4;
    localparam int BIT = 4 * Q;
`ifdef I2C_MASTER_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef struct {
        int lat; int ndone; int nstart; int nstop; int nrise;
        logic [7:0] abyte; logic [7:0] dbyte; logic [7:0] dout;
        logic b17; logic aerr; logic busy0; logic busy_end;
    } obs_t;

    typedef struct {
        int lat; int nrise; bit full;
        logic [7:0] abyte; logic [7:0] dbyte; logic [7:0] dout; logic aerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    wire  sda;
    logic slave_low;
    logic ack_en;
    logic [7:0] rd_byte;
    logic [7:0] exp_dout;
    int checks = 0;
    int errors = 0;

    int slot, starts, stops, dones, pend;
    logic [31:0] bits;
    logic pscl, psda;

    i2c_master_if bus();

    i2c_master #(.sys_freq(SYS), .i2c_freq(I2C)) dut (
        .clk(clk), .rst(rst), .bus(bus), .scl(scl), .sda(sda)
    );

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    // Slave behaviour for the slot about to be transferred (0-7 address, 8 ack, 9-16 data, 17 ack).
    function automatic logic drives_low(int s);
        if (s == 8) return ack_en;
        if (s >= 9 && s <= 16 && bits[7] && ack_en) return !rd_byte[16 - s];
        if (s == 17 && !bits[7] && ack_en) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] byte_at(int off);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = bits[off + i];
        return b;
    endfunction

    function automatic exp_t model(logic m_op, logic [6:0] m_addr, logic [7:0] m_din,
                                   logic m_ack, logic [7:0] m_rd, logic [7:0] m_prev);
        exp_t e;
        e.full  = !(ABORT && !m_ack);
        e.lat   = (e.full ? 20 : 11) * BIT;
        e.nrise = e.full ? 19 : 10;
        e.abyte = {m_addr, m_op};
        e.aerr  = !m_ack;
        e.dbyte = m_op ? (m_ack ? m_rd : 8'hFF) : m_din;
        e.dout  = (e.full && m_op) ? e.dbyte : m_prev;
        return e;
    endfunction

    // Bus monitor and slave: counts START/STOP (sda edges while scl high), records bits on scl rise.
    initial begin
        slave_low = 1'b0; pend = 0; slot = 0; starts = 0; stops = 0; dones = 0; bits = '0;
        pscl = 1'b1; psda = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
            if (pscl && scl && psda && !sda) begin starts++; slot = 0; bits = '0; end
            if (pscl && scl && !psda && sda) stops++;
            if (!pscl && scl) begin
                if (slot < 32) bits[slot] = sda;
                slot++;
            end
            if (pscl && !scl) begin
                slave_low = 1'b0;
                pend = 3 * Q / 2;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) slave_low = drives_low(slot);
            end
            pscl = scl;
            psda = sda;
        end
    end

    task automatic run_txn(input logic t_op, input logic [6:0] t_addr, input logic [7:0] t_din,
                           input logic t_ack, input logic [7:0] t_rd, input int inject_at,
                           output obs_t o);
        int d0, s0, p0;
        ack_en = t_ack; rd_byte = t_rd;
        @(negedge clk);
        bus.newd = 1'b1; bus.op = t_op; bus.addr = t_addr; bus.din = t_din;
        @(posedge clk); #1;
        bus.newd = 1'b0;
        d0 = dones; s0 = starts; p0 = stops;
        o.busy0 = bus.busy;
        o.lat = -1;
        for (int n = 1; n <= 20 * BIT + 200; n++) begin
            @(posedge clk); #1;
            if (n == inject_at) begin
                bus.newd = 1'b1; bus.op = ~t_op; bus.addr = ~t_addr; bus.din = ~t_din;
            end
            if (n == inject_at + 2) bus.newd = 1'b0;
            if (bus.done === 1'b1) begin o.lat = n; break; end
        end
        repeat (5) @(posedge clk);
        #1;
        o.ndone = dones - d0; o.nstart = starts - s0; o.nstop = stops - p0; o.nrise = slot;
        o.abyte = byte_at(0); o.dbyte = byte_at(9); o.b17 = bits[17];
        o.aerr = bus.ack_err; o.dout = bus.dout; o.busy_end = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0", bus.ack_err); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", bus.dout); end
    endtask

    task automatic test_write();
        obs_t o; exp_t e;
        e = model(1'b0, 7'h12, 8'h55, 1'b1, 8'h00, exp_dout);
        run_txn(1'b0, 7'h12, 8'h55, 1'b1, 8'h00, 0, o);
        exp_dout = e.dout;
        checks++; if (o.busy0 !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", o.busy0); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL write_latency got %0d want %0d", o.lat, e.lat); end
        checks++; if (o.abyte !== e.abyte) begin errors++; $display("FAIL write_addr_byte got %h want %h", o.abyte, e.abyte); end
        checks++; if (o.dbyte !== e.dbyte) begin errors++; $display("FAIL write_data_byte got %h want %h", o.dbyte, e.dbyte); end
        checks++; if (o.aerr !== e.aerr) begin errors++; $display("FAIL write_ack_err got %b want %b", o.aerr, e.aerr); end
        checks++; if (o.nstart !== 1 || o.nstop !== 1) begin errors++; $display("FAIL write_start_stop got %0d/%0d want 1/1", o.nstart, o.nstop); end
        checks++; if (o.ndone !== 1) begin errors++; $display("FAIL write_done_pulses got %0d want 1", o.ndone); end
    endtask

    task automatic test_read();
        obs_t o; exp_t e;
        e = model(1'b1, 7'h05, 8'h00, 1'b1, 8'hA3, exp_dout);
        run_txn(1'b1, 7'h05, 8'h00, 1'b1, 8'hA3, 0, o);
        exp_dout = e.dout;
        checks++; if (o.abyte !== e.abyte) begin errors++; $display("FAIL read_addr_byte got %h want %h", o.abyte, e.abyte); end
        checks++; if (o.dout !== e.dout) begin errors++; $display("FAIL read_dout got %h want %h", o.dout, e.dout); end
        checks++; if (o.b17 !== 1'b1) begin errors++; $display("FAIL read_master_nack got %b want 1", o.b17); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL read_latency got %0d want %0d", o.lat, e.lat); end
        checks++; if (o.aerr !== e.aerr) begin errors++; $display("FAIL read_ack_err got %b want %b", o.aerr, e.aerr); end
    endtask

    task automatic test_addr_nack();
        obs_t o; exp_t e;
        e = model(1'b0, 7'h33, 8'h9C, 1'b0, 8'h00, exp_dout);
        run_txn(1'b0, 7'h33, 8'h9C, 1'b0, 8'h00, 0, o);
        exp_dout = e.dout;
        checks++; if (o.aerr !== e.aerr) begin errors++; $display("FAIL nack_ack_err got %b want %b", o.aerr, e.aerr); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL nack_latency got %0d want %0d", o.lat, e.lat); end
        checks++; if (o.nrise !== e.nrise) begin errors++; $display("FAIL nack_scl_pulses got %0d want %0d", o.nrise, e.nrise); end
        checks++; if (o.nstop !== 1) begin errors++; $display("FAIL nack_stop got %0d want 1", o.nstop); end
        checks++; if (o.dout !== e.dout) begin errors++; $display("FAIL nack_dout got %h want %h", o.dout, e.dout); end
    endtask

    task automatic test_ignore();
        obs_t o; exp_t e;
        e = model(1'b0, 7'h4C, 8'hE1, 1'b1, 8'h00, exp_dout);
        run_txn(1'b0, 7'h4C, 8'hE1, 1'b1, 8'h00, 3000, o);
        exp_dout = e.dout;
        checks++; if (o.abyte !== e.abyte) begin errors++; $display("FAIL ignore_addr_byte got %h want %h", o.abyte, e.abyte); end
        checks++; if (o.dbyte !== e.dbyte) begin errors++; $display("FAIL ignore_data_byte got %h want %h", o.dbyte, e.dbyte); end
        checks++; if (o.ndone !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d want 1", o.ndone); end
        checks++; if (o.busy_end !== 1'b0) begin errors++; $display("FAIL ignore_requeued got busy %b want 0", o.busy_end); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL ignore_latency got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        int d0;
        ack_en = 1'b1;
        @(negedge clk);
        bus.newd = 1'b1; bus.op = 1'b0; bus.addr = 7'h2A; bus.din = 8'hC3;
        @(posedge clk); #1;
        bus.newd = 1'b0;
        d0 = dones;
        repeat (13 * BIT + Q + Q / 2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", bus.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL midrst_scl got %b want 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL midrst_sda got %b want 1", sda); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h want 00", bus.dout); end
        rst = 1'b0;
        exp_dout = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dones - d0 !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones - d0); end
        e = model(1'b0, 7'h61, 8'h0F, 1'b1, 8'h00, exp_dout);
        run_txn(1'b0, 7'h61, 8'h0F, 1'b1, 8'h00, 0, o);
        exp_dout = e.dout;
        checks++; if (o.nstart !== 1) begin errors++; $display("FAIL midrst_clean_start got %0d want 1", o.nstart); end
        checks++; if (o.abyte !== e.abyte) begin errors++; $display("FAIL midrst_addr_byte got %h want %h", o.abyte, e.abyte); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL midrst_latency got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            obs_t o; exp_t e;
            logic r_op, r_ack;
            logic [6:0] r_addr;
            logic [7:0] r_din, r_rd;
            r_op   = 1'($urandom_range(0, 1));
            r_addr = 7'($urandom);
            r_din  = 8'($urandom);
            r_rd   = 8'($urandom);
            r_ack  = ($urandom_range(0, 3) != 0);
            e = model(r_op, r_addr, r_din, r_ack, r_rd, exp_dout);
            run_txn(r_op, r_addr, r_din, r_ack, r_rd, 0, o);
            exp_dout = e.dout;
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", k, o.lat, e.lat); end
            checks++; if (o.abyte !== e.abyte) begin errors++; $display("FAIL rand%0d_addr_byte got %h want %h", k, o.abyte, e.abyte); end
            checks++; if (o.aerr !== e.aerr) begin errors++; $display("FAIL rand%0d_ack_err got %b want %b", k, o.aerr, e.aerr); end
            checks++; if (o.dout !== e.dout) begin errors++; $display("FAIL rand%0d_dout got %h want %h", k, o.dout, e.dout); end
            checks++; if (o.nrise !== e.nrise) begin errors++; $display("FAIL rand%0d_scl_pulses got %0d want %0d", k, o.nrise, e.nrise); end
            checks++; if (o.nstart !== 1 || o.nstop !== 1 || o.ndone !== 1) begin
                errors++; $display("FAIL rand%0d_start_stop_done got %0d/%0d/%0d want 1/1/1", k, o.nstart, o.nstop, o.ndone);
            end
            if (e.full && !r_op) begin
                checks++; if (o.dbyte !== e.dbyte) begin errors++; $display("FAIL rand%0d_data_byte got %h want %h", k, o.dbyte, e.dbyte); end
            end
            if (e.full && r_op) begin
                checks++; if (o.b17 !== 1'b1) begin errors++; $display("FAIL rand%0d_master_nack got %b want 1", k, o.b17); end
            end
        end
    endtask

    initial begin
        bus.newd = 1'b0; bus.op = 1'b0; bus.addr = 7'h00; bus.din = 8'h00;
        ack_en = 1'b1; rd_byte = 8'h00; exp_dout = 8'h00; rst = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter sys_freq, default 40000000: system clock frequency in Hz.
REQ-002 Parameter i2c_freq, default 100000: SCL bit rate in Hz.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port newd, input, 1 bit: transaction request; sampled only in idle.
REQ-006 Port op, input, 1 bit: 1 = read, 0 = write; captured with newd.
REQ-007 Port addr, input, 7 bits: slave address; captured with newd.
REQ-008 Port din, input, 8 bits: write data; captured with newd.
REQ-009 Port dout, output, 8 bits: last byte read from the slave.
REQ-010 Port busy, output, 1 bit: transaction in progress.
REQ-011 Port ack_err, output, 1 bit: slave NACK seen in the last transaction.
REQ-012 Port done, output, 1 bit: one-cycle end-of-transaction pulse.
REQ-013 Port scl, output, 1 bit: I2C clock, push-pull.
REQ-014 Port sda, inout, 1 bit: I2C data; driven when sda_en=1, otherwise high-Z (external pull-up).

Function
REQ-015 Timing SHALL be quarter-bit based: q = sys_freq/i2c_freq/4 clk cycles (100 at defaults); bit period = 4q, phases 0-3; phase counter SHALL hold at zero while idle.
REQ-016 For data and ack bits, scl SHALL be low in phases 0-1 and high in phases 2-3.
REQ-017 sda changes SHALL occur only at the start of phase 1; sda sampling SHALL occur at the first cycle of phase 2.
REQ-018 FSM states SHALL be: IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, MACK, STOP.
REQ-019 IDLE: scl=1, sda released; on newd=1, capture op/addr/din, set busy=1, clear ack_err, go to START.
REQ-020 START SHALL last one bit period: scl=1 throughout; sda driven 1 in phases 0-1 and 0 in phases 2-3.
REQ-021 ADDR SHALL shift out {addr, op} MSB first over 8 bit periods, then go to ACK1.
REQ-022 ACK1 SHALL release sda and sample the ack bit; 1 sets ack_err; next state WDATA if op=0, else RDATA.
REQ-023 WDATA SHALL shift out captured din MSB first over 8 bit periods, then go to ACK2.
REQ-024 ACK2 SHALL release sda and sample the ack bit; 1 sets ack_err; next state STOP.
REQ-025 RDATA SHALL release sda and shift 8 sampled bits MSB first into dout; dout SHALL update only when the 8th bit is captured; next state MACK.
REQ-026 MACK SHALL drive sda=1 (NACK, single-byte read) for one bit period; next state STOP.
REQ-027 STOP SHALL last one bit period: phase 0 scl=0/sda=0; phase 1 scl=1/sda=0; phases 2-3 scl=1/sda=1.
REQ-028 On the last cycle of STOP, the FSM SHALL go to IDLE, release sda, set busy=0, and pulse done for exactly one cycle.
REQ-029 A full transaction SHALL be 20 bit periods (8000 clk at defaults) from newd acceptance to done.
REQ-030 newd asserted while busy=1 SHALL be ignored; it SHALL NOT queue.
REQ-031 Changes to addr/din/op after capture SHALL NOT affect the transaction in progress.

Reset
REQ-032 rst=1 SHALL force IDLE from any state, including mid-transaction; it SHALL set scl=1, sda released, busy=0, done=0, ack_err=0, dout=0x00, and clear the bit and phase counters.

Configuration
REQ-033 Macro I2C_MASTER_NACK_ABORT_EN defined: a NACK in ACK1 SHALL branch directly to STOP, skipping the data phase; the transaction is then 11 bit periods (4400 clk at defaults) and dout is unchanged.
REQ-034 Macro I2C_MASTER_NACK_ABORT_EN undefined: an ACK1 NACK SHALL set ack_err and the transaction SHALL complete in the full 20 bit periods.

Verification
REQ-035 Write: addr=0x12, op=0, din=0x55, slave ACKs -> bus bytes 0x24 then 0x55; done at cycle 8000; ack_err=0.
REQ-036 Read: addr=0x05, op=1, slave returns 0xA3 -> address byte 0x0B; dout=0xA3; master NACK in MACK; done at cycle 8000.
REQ-037 Address NACK (sda held high), op=0 -> ack_err=1; done at 4400 with the macro defined, at 8000 without it.
REQ-038 newd pulsed mid-transaction with different addr -> ignored; bus shows the original address; exactly one done pulse.
REQ-039 rst asserted during WDATA bit 3 -> next cycle: scl=1, sda=Z, busy=0, done=0; a following newd starts a clean START.
REQ-040 START/STOP checker: sda transitions only while scl=0, except the START falling edge and the STOP rising edge while scl=1.
